// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FAULT    = 2'd2
    } ctrl_state_e;

    localparam logic [31:0] NOP                 = 32'h00000013;
    localparam int unsigned MEM_TIMEOUT_DEFAULT = 255;
    localparam logic [4:0]  REG_ZERO            = 5'd0;

endpackage

// File: rtl/hazard_ctrl_load_use_detect.sv
// Load-use detection: the load in EX writes a register the ID instruction reads.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_mem_read,
    output logic       load_use
);

    logic rs1_hit;
    logic rs2_hit;

    always_comb begin
        rs1_hit  = id_uses_rs1 && (ex_rd == id_rs1);
        rs2_hit  = id_uses_rs2 && (ex_rd == id_rs2);
        // x0 is hardwired to zero, so a load targeting it never creates a dependency
        load_use = ex_mem_read && (ex_rd != REG_ZERO) && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/flush priority, memory-wait FSM with
// timeout fault, and stall/flush performance counters.
module hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic        ex_branch_taken,
    input  logic        dmem_req,
    input  logic        dmem_ready,
    output logic        pc_en,
    output logic        if_id_stall,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        ex_mem_stall,
    output logic        mem_wb_bubble,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt,
    output logic [1:0]  state,
    output logic        mem_timeout
);

    localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT);

    ctrl_state_e state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;
    logic        mem_timeout_q, mem_timeout_d;

    logic load_use;
    logic mem_stall;

    load_use_detect u_load_use_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .load_use    (load_use)
    );

    assign mem_stall = dmem_req && !dmem_ready;

    // A taken branch under mem_stall needs no storage: EX is frozen, so the
    // branch is still presented and acts as soon as the stall clears.
    always_comb begin
        pc_en         = 1'b1;
        if_id_stall   = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_stall  = 1'b0;
        mem_wb_bubble = 1'b0;
        if (rst) begin
            pc_en       = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if ((state_q == FAULT) || mem_stall) begin
            pc_en         = 1'b0;
            if_id_stall   = 1'b1;
            ex_mem_stall  = 1'b1;
            mem_wb_bubble = 1'b1;
        end else if (ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use) begin
            pc_en       = 1'b0;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        case (state_q)
            RUN: begin
                if (mem_stall) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = 8'd1;
                end
            end
            MEM_WAIT: begin
                if (!mem_stall) begin
                    state_d = RUN;
                end else if (wait_cnt_q == WAIT_LIMIT) begin
                    state_d       = FAULT;
                    mem_timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            FAULT:   state_d = FAULT;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pc_en && (state_q != FAULT)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (if_id_flush) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= RUN;
            wait_cnt_q    <= '0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;
    assign state       = state_q;
    assign mem_timeout = mem_timeout_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl: table of single-cycle hazard
// vectors plus hand-written memory-wait, reset and timeout sequences.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken;
    logic        dmem_req, dmem_ready;
    logic        pc_en, if_id_stall, if_id_flush, id_ex_flush, ex_mem_stall, mem_wb_bubble;
    logic [31:0] stall_cnt, flush_cnt;
    logic [1:0]  state;
    logic        mem_timeout;
    logic [5:0]  outs;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_stall = 0;
    logic [31:0] exp_flush = 0;

    // {pc_en, if_id_stall, if_id_flush, id_ex_flush, ex_mem_stall, mem_wb_bubble}
    localparam logic [5:0] O_NORMAL = 6'b100000;
    localparam logic [5:0] O_LOAD   = 6'b010100;
    localparam logic [5:0] O_BRANCH = 6'b101100;
    localparam logic [5:0] O_FREEZE = 6'b010011;
    localparam logic [5:0] O_RESET  = 6'b001100;

    hazard_ctrl #(.MEM_TIMEOUT(255)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .ex_rd           (ex_rd),
        .ex_mem_read     (ex_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .dmem_req        (dmem_req),
        .dmem_ready      (dmem_ready),
        .pc_en           (pc_en),
        .if_id_stall     (if_id_stall),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .ex_mem_stall    (ex_mem_stall),
        .mem_wb_bubble   (mem_wb_bubble),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt),
        .state           (state),
        .mem_timeout     (mem_timeout)
    );

    assign outs = {pc_en, if_id_stall, if_id_flush, id_ex_flush, ex_mem_stall, mem_wb_bubble};

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [4:0] rs1, rs2, rd;
        logic       u1, u2, mr, br, dreq, drdy;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic u1, input logic u2, input logic mr, input logic br,
                          input logic dreq, input logic drdy);
        id_rs1 = rs1; id_rs2 = rs2; ex_rd = rd;
        id_uses_rs1 = u1; id_uses_rs2 = u2; ex_mem_read = mr;
        ex_branch_taken = br; dmem_req = dreq; dmem_ready = drdy;
    endtask

    initial begin
        //            name            rs1 rs2 rd  u1 u2 mr br dq dr  exp
        vecs[0] = '{"idle",          5'd1, 5'd2, 5'd3, 1, 1, 0, 0, 0, 0, O_NORMAL};
        vecs[1] = '{"lu_rs2",        5'd3, 5'd5, 5'd5, 1, 1, 1, 0, 0, 0, O_LOAD};
        vecs[2] = '{"lu_rd_zero",    5'd0, 5'd0, 5'd0, 1, 1, 1, 0, 0, 0, O_NORMAL};
        vecs[3] = '{"lu_rs1",        5'd7, 5'd2, 5'd7, 1, 0, 1, 0, 0, 0, O_LOAD};
        vecs[4] = '{"rs1_not_used",  5'd7, 5'd2, 5'd7, 0, 1, 1, 0, 0, 0, O_NORMAL};
        vecs[5] = '{"not_a_load",    5'd9, 5'd9, 5'd9, 1, 1, 0, 0, 0, 0, O_NORMAL};
        vecs[6] = '{"branch",        5'd1, 5'd2, 5'd3, 1, 1, 0, 1, 0, 0, O_BRANCH};
        vecs[7] = '{"branch_over_lu",5'd3, 5'd5, 5'd5, 0, 1, 1, 1, 0, 0, O_BRANCH};
        vecs[8] = '{"mem_ready",     5'd1, 5'd2, 5'd3, 1, 1, 0, 0, 1, 1, O_NORMAL};
        vecs[9] = '{"lu_r31_noreq",  5'd4, 5'd31,5'd31,1, 1, 1, 0, 0, 1, O_LOAD};

        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        #1;
        check("reset_outs", 32'(outs), 32'(O_RESET));
        check("reset_state", 32'(state), 32'd0);
        check("reset_stall_cnt", stall_cnt, 32'd0);
        check("reset_flush_cnt", flush_cnt, 32'd0);
        check("reset_timeout", 32'(mem_timeout), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            set_in(vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].u1, vecs[i].u2,
                   vecs[i].mr, vecs[i].br, vecs[i].dreq, vecs[i].drdy);
            #1;
            check(vecs[i].name, 32'(outs), 32'(vecs[i].exp));
            if (!vecs[i].exp[5]) exp_stall++;
            if (vecs[i].exp[3]) exp_flush++;
        end
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("table_stall_cnt", stall_cnt, exp_stall);
        check("table_flush_cnt", flush_cnt, exp_flush);

        // Memory stall overlapping a taken branch: freeze, then redirect.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            set_in(5'd3, 5'd5, 5'd5, 1, 1, 1, 1, 1, 0);
            #1;
            check("memwait_freeze", 32'(outs), 32'(O_FREEZE));
            @(posedge clk);
            #1;
            check("memwait_state", 32'(state), 32'd1);
            exp_stall++;
        end
        @(negedge clk);
        dmem_ready = 1'b1;
        #1;
        check("held_branch", 32'(outs), 32'(O_BRANCH));
        exp_flush++;
        @(posedge clk);
        #1;
        check("back_to_run", 32'(state), 32'd0);
        check("memwait_stall_cnt", stall_cnt, exp_stall);
        check("memwait_flush_cnt", flush_cnt, exp_flush);

        // Asynchronous reset in the middle of a memory wait.
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
        repeat (2) @(posedge clk);
        #1;
        check("wait_before_rst", 32'(state), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_state", 32'(state), 32'd0);
        check("async_rst_stall", stall_cnt, 32'd0);
        check("async_rst_flush", flush_cnt, 32'd0);
        check("async_rst_outs", 32'(outs), 32'(O_RESET));
        @(negedge clk);
        rst = 1'b0;
        dmem_req = 1'b0;
        #1;
        check("post_rst_idle", 32'(outs), 32'(O_NORMAL));
        @(posedge clk);
        #1;
        check("post_rst_state", 32'(state), 32'd0);
        check("post_rst_stall", stall_cnt, 32'd0);

        // Timeout: 255 stalled cycles still waiting, the 256th enters FAULT.
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
        repeat (255) @(posedge clk);
        #1;
        check("wait_at_limit", 32'(state), 32'd1);
        check("no_timeout_yet", 32'(mem_timeout), 32'd0);
        @(posedge clk);
        #1;
        check("fault_state", 32'(state), 32'd2);
        check("fault_flag", 32'(mem_timeout), 32'd1);
        check("fault_stall_cnt", stall_cnt, 32'd256);
        @(negedge clk);
        set_in(5'd1, 5'd2, 5'd3, 1, 1, 0, 1, 0, 0);
        #1;
        check("fault_frozen", 32'(outs), 32'(O_FREEZE));
        repeat (3) @(posedge clk);
        #1;
        check("fault_sticky", 32'(state), 32'd2);
        check("fault_no_count", stall_cnt, 32'd256);
        check("fault_flush_cnt", flush_cnt, 32'd0);
        rst = 1'b1;
        #1;
        check("fault_rst_state", 32'(state), 32'd0);
        check("fault_rst_flag", 32'(mem_timeout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("fault_rst_idle", 32'(outs), 32'(O_NORMAL));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
